viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code produced by the `encoder2` block. It sits after the channel in the transmit/receive path. On each enabled clock it takes one 2-bit code symbol and emits one decoded data bit at a fixed latency. It uses register-exchange survivor storage.

---
 rtl/viterbi_decoder.sv | 119 +++++++++++
 tb/tb_viterbi_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the rate-1/2, K=3 (7,5) code.
// Define VITERBI_BEST_STATE_EN to take d_out from the minimum-metric state instead of state 0.
module viterbi_decoder #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  localparam int unsigned N_STATES = 4;
  localparam int unsigned SUM_W    = PM_W + 1;
  localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};
  localparam logic [PM_W-1:0]  PM_INIT  = (PM_W >= 5) ? PM_W'(16) : PM_MAX;
  localparam logic [SUM_W-1:0] SUM_SAT  = {1'b0, PM_MAX};

  logic [PM_W-1:0]     pm_q     [N_STATES];
  logic [PM_W-1:0]     pm_d     [N_STATES];
  logic [TB_DEPTH-1:0] surv_q   [N_STATES];
  logic [TB_DEPTH-1:0] surv_d   [N_STATES];
  logic [TB_DEPTH-1:0] surv_new [N_STATES];
  logic [SUM_W-1:0]    acs_pm   [N_STATES];
  logic [SUM_W-1:0]    norm_pm  [N_STATES];
  logic                d_out_q;
  logic                d_out_d;

  logic [SUM_W-1:0]    lo_min;
  logic [SUM_W-1:0]    hi_min;
  logic [SUM_W-1:0]    min_pm;
  logic                lo_sel;
  logic                hi_sel;
  logic                top_sel;
  logic [1:0]          best;

  // Hamming distance between the received symbol and the branch output from pred with input b
  function automatic logic [1:0] branch_metric(input logic [1:0] sym, input logic b,
                                               input logic [1:0] pred);
    logic [1:0] exp_sym;
    logic [1:0] diff;
    exp_sym = {b ^ pred[1] ^ pred[0], b ^ pred[0]};
    diff    = sym ^ exp_sym;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // Add-compare-select, normalization and survivor exchange for all four states
  always_comb begin
    for (int i = 0; i < N_STATES; i++) begin
      logic [1:0]       ns;
      logic [1:0]       p0;
      logic [1:0]       p1;
      logic [SUM_W-1:0] cand0;
      logic [SUM_W-1:0] cand1;
      logic             sel;
      ns    = 2'(i);
      p0    = {ns[0], 1'b0};
      p1    = {ns[0], 1'b1};
      cand0 = SUM_W'(pm_q[p0]) + SUM_W'(branch_metric(d_in, ns[1], p0));
      cand1 = SUM_W'(pm_q[p1]) + SUM_W'(branch_metric(d_in, ns[1], p1));
      sel   = (cand1 < cand0);
      acs_pm[i]   = sel ? cand1 : cand0;
      surv_new[i] = sel ? {surv_q[p1][TB_DEPTH-2:0], ns[1]}
                        : {surv_q[p0][TB_DEPTH-2:0], ns[1]};
    end

    lo_sel  = (acs_pm[1] < acs_pm[0]);
    lo_min  = lo_sel ? acs_pm[1] : acs_pm[0];
    hi_sel  = (acs_pm[3] < acs_pm[2]);
    hi_min  = hi_sel ? acs_pm[3] : acs_pm[2];
    top_sel = (hi_min < lo_min);
    min_pm  = top_sel ? hi_min : lo_min;

`ifdef VITERBI_BEST_STATE_EN
    best = top_sel ? {1'b1, hi_sel} : {1'b0, lo_sel};
`else
    best = 2'd0;
`endif

    for (int i = 0; i < N_STATES; i++) begin
      norm_pm[i] = acs_pm[i] - min_pm;
    end

    pm_d    = pm_q;
    surv_d  = surv_q;
    d_out_d = d_out_q;
    if (enable) begin
      for (int i = 0; i < N_STATES; i++) begin
        pm_d[i]   = (norm_pm[i] > SUM_SAT) ? PM_MAX : PM_W'(norm_pm[i]);
        surv_d[i] = surv_new[i];
      end
      d_out_d = surv_new[best][TB_DEPTH-1];
    end
  end

  // State registers; reset forces decoding to start from the all-zero state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q[0] <= '0;
      for (int i = 1; i < N_STATES; i++) begin
        pm_q[i] <= PM_INIT;
      end
      for (int i = 0; i < N_STATES; i++) begin
        surv_q[i] <= '0;
      end
      d_out_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_STATES; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_d[i];
      end
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: vector table plus encoder-model scoreboard streams.
module tb_viterbi_decoder;

  localparam int unsigned TB_DEPTH = 16;
  localparam int unsigned PM_W     = 6;
  localparam int unsigned N_SRC    = 256;
  localparam int unsigned LAT      = TB_DEPTH - 1;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] d_in;
  logic       d_out;

  int         n_checks;
  int         n_fail;
  logic       src [N_SRC];
  logic [1:0] enc_s;
  logic       exp_q [$];
  logic       last_exp;

  typedef struct {
    logic       en;
    logic [1:0] sym;
    logic       exp_out;
  } vec_t;
  vec_t tbl [24];

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d_in   (d_in),
    .d_out  (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: d_out=%0b expected %0b at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic sb_reset();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(1'b0);
    last_exp = 1'b0;
    enc_s    = 2'b00;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    enable = 1'b0;
    d_in   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", d_out, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sb_reset();
  endtask

  // Drive one cycle; enabled cycles push the source bit and pop the expected decoded bit
  task automatic step(input logic en, input logic [1:0] sym, input logic src_bit, input string name);
    enable = en;
    d_in   = sym;
    if (en) exp_q.push_back(src_bit);
    @(posedge clk);
    #1;
    if (en) begin
      if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    end
    check(name, d_out, last_exp);
  endtask

  task automatic fill_src();
    for (int i = 0; i < N_SRC; i++) src[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_stream(input int nsym, input bit inj_err, input bit gaps, input string name);
    for (int n = 0; n < nsym; n++) begin
      logic       b;
      logic [1:0] sym;
      b     = (n < N_SRC) ? src[n] : 1'b0;
      sym   = {b ^ enc_s[1] ^ enc_s[0], b ^ enc_s[0]};
      enc_s = {b, enc_s[1]};
      if (inj_err && (n % 32 == 20)) sym = sym ^ (((n / 32) % 2 == 1) ? 2'b01 : 2'b10);
      if (gaps && n > 0 && $urandom_range(0, 24) == 0) begin
        repeat (5) step(1'b0, 2'($urandom_range(0, 3)), 1'b0, "gap_hold");
      end
      step(1'b1, sym, b, name);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    enable   = 1'b0;
    d_in     = 2'b00;
    last_exp = 1'b0;
    enc_s    = 2'b00;

    // Single data 1 followed by zeros, with an idle gap holding the 1
    for (int i = 0; i < 24; i++) begin
      tbl[i].en      = 1'b1;
      tbl[i].sym     = 2'b00;
      tbl[i].exp_out = 1'b0;
    end
    tbl[0].sym      = 2'b11;
    tbl[1].sym      = 2'b10;
    tbl[2].sym      = 2'b11;
    tbl[15].exp_out = 1'b1;
    tbl[16].en      = 1'b0;
    tbl[16].sym     = 2'b11;
    tbl[16].exp_out = 1'b1;
    tbl[17].en      = 1'b0;
    tbl[17].sym     = 2'b01;
    tbl[17].exp_out = 1'b1;

    do_reset();
    for (int i = 0; i < 24; i++) begin
      enable = tbl[i].en;
      d_in   = tbl[i].sym;
      @(posedge clk);
      #1;
      check($sformatf("single_one[%0d]", i), d_out, tbl[i].exp_out);
    end

    // All zeros
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 2'b00, 1'b0, "all_zeros");

    // Random error-free, then isolated errors, then enable gaps on the same source
    fill_src();
    do_reset();
    run_stream(N_SRC + LAT, 1'b0, 1'b0, "random_clean");
    do_reset();
    run_stream(N_SRC + LAT, 1'b1, 1'b0, "isolated_err");
    do_reset();
    run_stream(N_SRC + LAT, 1'b0, 1'b1, "enable_gaps");

    // Reset mid-stream: d_out known to be 1 just before reset
    fill_src();
    src[84] = 1'b1;
    do_reset();
    run_stream(100, 1'b0, 1'b0, "pre_reset");
    check("pre_reset_one", d_out, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", d_out, 1'b0);
    enable = 1'b1;
    d_in   = 2'b11;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", d_out, 1'b0);
    end
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    sb_reset();
    fill_src();
    run_stream(N_SRC + LAT, 1'b0, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
